result_sram_writer: RTL

//  Downstream stage of the compute datapath. Accepts 16-bit result words over a valid/ready stream,

---
 rtl/result_sram_writer_if.sv | 34 +++
 rtl/result_sram_writer.sv | 112 +++++++++++
 2 files changed

// File: rtl/result_sram_writer_if.sv
// Stream, job-control and SRAM-write signals of result_sram_writer.
//   master : the side that supplies jobs, result words and the write grant
//   slave  : result_sram_writer itself
// Signals: start, base_addr, num_results, in_valid, in_data, in_ready,
//          sram_wr_grant, dut_sram_write_enable/address/data, busy, done.
interface result_sram_writer_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH-1:0] num_results;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  sram_wr_grant;
   logic                  dut_sram_write_enable;
   logic [ADDR_WIDTH-1:0] dut_sram_write_address;
   logic [DATA_WIDTH-1:0] dut_sram_write_data;
   logic                  busy;
   logic                  done;

   modport master (
      output start, base_addr, num_results, in_valid, in_data, sram_wr_grant,
      input  in_ready, dut_sram_write_enable, dut_sram_write_address,
             dut_sram_write_data, busy, done
   );

   modport slave (
      input  start, base_addr, num_results, in_valid, in_data, sram_wr_grant,
      output in_ready, dut_sram_write_enable, dut_sram_write_address,
             dut_sram_write_data, busy, done
   );
endinterface

// File: rtl/result_sram_writer.sv
// result_sram_writer: buffers result words in a small FIFO and writes them to
// consecutive output-SRAM addresses starting at a latched base address.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   bus (slave) : job control (start/base_addr/num_results), input stream
//                 (in_valid/in_data/in_ready), shared write port
//                 (sram_wr_grant, registered dut_sram_write_*), busy, done
//   dbg_state   : current FSM state
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready comes from registered state only, never from in_valid or grant.
module result_sram_writer #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   result_sram_writer_if.slave bus,
   output logic [1:0]         dbg_state
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         fifo_count;
   logic [ADDR_WIDTH:0]   accepted, written;
   logic [ADDR_WIDTH-1:0] base_r, num_r;
   logic                  in_ready_c, push, pop, last_write;

   always_comb begin
      in_ready_c = (state == S_RUN) && (fifo_count < CW'(FIFO_DEPTH)) &&
                   (accepted < {1'b0, num_r});
      push       = bus.in_valid && in_ready_c;
      pop        = (state == S_RUN) && (fifo_count != '0) && bus.sram_wr_grant;
      // This pop performs write number num_results.
      last_write = pop && ((written + (ADDR_WIDTH+1)'(1)) == {1'b0, num_r});
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = (bus.num_results == '0) ? S_DONE : S_RUN;
         S_RUN:   if (last_write) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= bus.in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr                     <= '0;
         rd_ptr                     <= '0;
         fifo_count                 <= '0;
         accepted                   <= '0;
         written                    <= '0;
         base_r                     <= '0;
         num_r                      <= '0;
         bus.dut_sram_write_enable  <= 1'b0;
         bus.dut_sram_write_address <= '0;
         bus.dut_sram_write_data    <= '0;
      end else begin
         bus.dut_sram_write_enable <= 1'b0;
         if (state == S_IDLE && bus.start) begin
            base_r     <= bus.base_addr;
            num_r      <= bus.num_results;
            accepted   <= '0;
            written    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
         end
         if (push) begin
            wr_ptr   <= wr_ptr + PW'(1);
            accepted <= accepted + (ADDR_WIDTH+1)'(1);
         end
         if (pop) begin
            // Address and data only change on a write; they hold otherwise.
            bus.dut_sram_write_enable  <= 1'b1;
            bus.dut_sram_write_address <= base_r + written[ADDR_WIDTH-1:0];
            bus.dut_sram_write_data    <= fifo_mem[rd_ptr];
            rd_ptr                     <= rd_ptr + PW'(1);
            written                    <= written + (ADDR_WIDTH+1)'(1);
         end
         if (push && !pop)      fifo_count <= fifo_count + CW'(1);
         else if (pop && !push) fifo_count <= fifo_count - CW'(1);
      end
   end

   assign bus.in_ready = in_ready_c;
   assign bus.busy     = (state == S_RUN);
   assign bus.done     = (state == S_DONE);
   assign dbg_state    = state;
endmodule
